// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared types and constants.
// State encoding, command bytes and default timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } ps2_state_t;

  localparam logic [7:0] CMD_LED    = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] DEV_ACK    = 8'hFA;

  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_RTS_CYCLES     = 10;
  localparam int DEF_TIMEOUT_CYCLES = 750000;

  localparam int CNT_W = 20;

  // {stop, odd parity, data, start}; bit 0 goes out first
  function automatic logic [10:0] ps2_frame(
    input logic [7:0] d
  );
    return {1'b1, ~^d, d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// Two-flop pad synchronizer with a registered
// falling-edge strobe.
module ps2_host_tx_sync (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic pin,
  output logic sync,
  output logic fall
);

  logic s1;
  logic prev;

  // idle bus reads high, so the chain resets to 1
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1   <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
      fall <= 1'b0;
    end else begin
      s1   <= pin;
      sync <= s1;
      prev <= sync;
      fall <= prev & ~sync;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, RTS,
// shift out on device clock falls, check ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int RTS_CYCLES     = DEF_RTS_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] send_data,
  input  logic       send_req,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam logic [CNT_W-1:0] INH_LAST =
    CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST =
    CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       state_q;
  ps2_state_t       state_d;
  logic [10:0]      shreg;
  logic [3:0]       bitcnt;
  logic [CNT_W-1:0] cnt;
  logic             dat_oe_q;
  logic             done_q;
  logic             error_q;

  logic clk_s;
  logic clk_fall;
  logic dat_s;
  logic dat_fall_unused;

  logic load;
  logic shift;
  logic cnt_clr;
  logic rts_enter;
  logic shift_enter;
  logic done_d;
  logic error_d;
  logic tmo;

  ps2_host_tx_sync u_clk_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .pin      (ps2_clk_in),
    .sync     (clk_s),
    .fall     (clk_fall)
  );

  ps2_host_tx_sync u_dat_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .pin      (ps2_dat_in),
    .sync     (dat_s),
    .fall     (dat_fall_unused)
  );

  assign tmo = (cnt == TMO_LAST);

  // next-state and per-cycle control strobes
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    shift       = 1'b0;
    cnt_clr     = 1'b0;
    rts_enter   = 1'b0;
    shift_enter = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (send_req) begin
          state_d = S_INHIBIT;
          load    = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      S_INHIBIT: begin
        if (cnt == INH_LAST) begin
          state_d   = S_RTS;
          cnt_clr   = 1'b1;
          rts_enter = 1'b1;
        end
      end
      S_RTS: begin
        if (cnt == RTS_LAST) begin
          state_d     = S_SHIFT;
          cnt_clr     = 1'b1;
          shift_enter = 1'b1;
        end
      end
      S_SHIFT: begin
        if (clk_fall) begin
          shift   = 1'b1;
          cnt_clr = 1'b1;
          if (bitcnt == 4'd9) state_d = S_ACK;
        end else if (tmo) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        if (clk_fall) begin
          cnt_clr = 1'b1;
          if (dat_s) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end else if (tmo) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tmo) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, datapath and pulse registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      cnt      <= '0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      error_q <= error_d;
      if (cnt_clr || state_q == S_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (load)
        shreg <= ps2_frame(send_data);
      else if (shift)
        shreg <= {1'b1, shreg[10:1]};
      if (shift_enter)
        bitcnt <= '0;
      else if (shift)
        bitcnt <= bitcnt + 1'b1;
      if (rts_enter)
        dat_oe_q <= ~shreg[0];
      else if (shift)
        dat_oe_q <= ~shreg[1];
      else if (state_d == S_IDLE)
        dat_oe_q <= 1'b0;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign error      = error_q;
  assign ps2_clk_oe = (state_q == S_INHIBIT) ||
                      (state_q == S_RTS);
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a scaled
// PS/2 device model driving the open-collector bus.
module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int RTS = 10;
  localparam int TMO = 400;
  localparam int H   = 20;
  // pad sync (2) + registered fall (1) + counter clear (1)
  localparam int LAT = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] send_data;
  logic       send_req;
  logic       busy;
  logic       done;
  logic       error;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int err_cyc   = 0;
  int busy_bad  = 0;
  int last_fall_cyc = 0;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .RTS_CYCLES     (RTS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .send_data  (send_data),
    .send_req   (send_req),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (done) done_cnt++;
    if (error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if ((done || error) && busy) busy_bad++;
  end

  task automatic clear_mon();
    done_cnt = 0;
    err_cnt  = 0;
    busy_bad = 0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge CLOCK_50);
    send_data = d;
    send_req  = 1'b1;
    @(negedge CLOCK_50);
    send_req  = 1'b0;
    send_data = 8'h00;
  endtask

  task automatic wait_not_busy(
    input int budget, output bit timed_out
  );
    int n = 0;
    while (busy && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    timed_out = busy;
    repeat (4) @(negedge CLOCK_50);
  endtask

  // device side: watch inhibit/RTS, clock the frame,
  // sample bits while CLK is low, then answer ACK
  task automatic device_frame(
    input  logic        ack_bit,
    input  int          stop_after,
    output logic [10:0] bits,
    output int          inh,
    output bit          ok
  );
    int n = 0;
    bits = '0;
    inh  = 0;
    ok   = 1'b1;
    while (!ps2_clk_oe && n < 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    while (ps2_clk_oe && !ps2_dat_oe && inh < 10*INH) begin
      inh++;
      @(negedge CLOCK_50);
    end
    n = 0;
    while (ps2_clk_oe && n < 10*RTS) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (ps2_clk_oe || inh == 0) begin
      ok = 1'b0;
      return;
    end
    bits[0] = ps2_dat_in;
    repeat (H/2) @(negedge CLOCK_50);
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (H) @(negedge CLOCK_50);
      bits[i] = ps2_dat_in;
      dev_clk = 1'b1;
      repeat (H) @(negedge CLOCK_50);
      if (i == stop_after) return;
    end
    dev_dat = ack_bit;
    repeat (4) @(negedge CLOCK_50);
    dev_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (H) @(negedge CLOCK_50);
    dev_clk = 1'b1;
    repeat (H) @(negedge CLOCK_50);
    dev_dat = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    send_req  = 1'b0;
    send_data = 8'h00;
    repeat (3) @(negedge CLOCK_50);
    total_cnt += 5;
    if (busy !== 1'b0)
      $display("FAIL reset_busy got %b want 0", busy);
    else pass_cnt++;
    if (done !== 1'b0)
      $display("FAIL reset_done got %b want 0", done);
    else pass_cnt++;
    if (error !== 1'b0)
      $display("FAIL reset_error got %b want 0", error);
    else pass_cnt++;
    if (ps2_clk_oe !== 1'b0)
      $display("FAIL reset_clk_oe got %b want 0", ps2_clk_oe);
    else pass_cnt++;
    if (ps2_dat_oe !== 1'b0)
      $display("FAIL reset_dat_oe got %b want 0", ps2_dat_oe);
    else pass_cnt++;
    reset = 1'b0;
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic test_enable();
    logic [10:0] bits;
    int inh;
    bit ok;
    bit to;
    clear_mon();
    send_byte(8'hF4);
    total_cnt++;
    if (ps2_clk_oe !== 1'b1)
      $display("FAIL f4_latency clk_oe got %b want 1", ps2_clk_oe);
    else pass_cnt++;
    device_frame(1'b0, 11, bits, inh, ok);
    wait_not_busy(500, to);
    total_cnt += 7;
    if (!ok) $display("FAIL f4_model got no RTS want RTS");
    else pass_cnt++;
    if (inh < INH)
      $display("FAIL f4_inhibit got %0d want >=%0d", inh, INH);
    else pass_cnt++;
    if (bits !== 11'b1_0_11110100_0)
      $display("FAIL f4_frame got %b want %b", bits, 11'b1_0_11110100_0);
    else pass_cnt++;
    if (to) $display("FAIL f4_busy got 1 want 0");
    else pass_cnt++;
    if (done_cnt != 1)
      $display("FAIL f4_done got %0d want 1", done_cnt);
    else pass_cnt++;
    if (err_cnt != 0)
      $display("FAIL f4_error got %0d want 0", err_cnt);
    else pass_cnt++;
    if (busy_bad != 0)
      $display("FAIL f4_busy_on_pulse got %0d want 0", busy_bad);
    else pass_cnt++;
  endtask

  task automatic test_parity_frames();
    logic [10:0] bits;
    int inh;
    bit ok;
    bit to;
    clear_mon();
    send_byte(8'hED);
    device_frame(1'b0, 11, bits, inh, ok);
    wait_not_busy(500, to);
    total_cnt += 2;
    if (!ok || bits !== 11'b1_1_11101101_0)
      $display("FAIL ed_frame got %b want %b", bits, 11'b1_1_11101101_0);
    else pass_cnt++;
    if (to || done_cnt != 1 || err_cnt != 0)
      $display("FAIL ed_done got %0d/%0d want 1/0", done_cnt, err_cnt);
    else pass_cnt++;
    clear_mon();
    send_byte(8'h00);
    device_frame(1'b0, 11, bits, inh, ok);
    wait_not_busy(500, to);
    total_cnt += 2;
    if (!ok || bits !== 11'b1_1_00000000_0)
      $display("FAIL zero_frame got %b want %b", bits, 11'b1_1_00000000_0);
    else pass_cnt++;
    if (to || done_cnt != 1 || err_cnt != 0)
      $display("FAIL zero_done got %0d/%0d want 1/0", done_cnt, err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_nack();
    logic [10:0] bits;
    int inh;
    bit ok;
    bit to;
    clear_mon();
    send_byte(8'hFF);
    device_frame(1'b1, 11, bits, inh, ok);
    wait_not_busy(500, to);
    total_cnt += 4;
    if (!ok || bits !== 11'b1_1_11111111_0)
      $display("FAIL ff_frame got %b want %b", bits, 11'b1_1_11111111_0);
    else pass_cnt++;
    if (to || err_cnt != 1)
      $display("FAIL nack_error got %0d want 1", err_cnt);
    else pass_cnt++;
    if (done_cnt != 0)
      $display("FAIL nack_done got %0d want 0", done_cnt);
    else pass_cnt++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0)
      $display("FAIL nack_release got %b%b want 00", ps2_clk_oe, ps2_dat_oe);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic [10:0] bits;
    int inh;
    bit ok;
    bit to;
    clear_mon();
    send_byte(8'hF4);
    device_frame(1'b0, 4, bits, inh, ok);
    wait_not_busy(3*TMO, to);
    total_cnt += 4;
    if (!ok || to || err_cnt != 1)
      $display("FAIL tmo_error got %0d want 1", err_cnt);
    else pass_cnt++;
    if (err_cyc - last_fall_cyc != TMO + LAT)
      $display("FAIL tmo_delay got %0d want %0d", err_cyc - last_fall_cyc, TMO + LAT);
    else pass_cnt++;
    if (done_cnt != 0)
      $display("FAIL tmo_done got %0d want 0", done_cnt);
    else pass_cnt++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0)
      $display("FAIL tmo_release got %b%b want 00", ps2_clk_oe, ps2_dat_oe);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    logic [10:0] bits;
    int inh;
    bit ok;
    bit to;
    clear_mon();
    send_byte(8'h0F);
    fork
      device_frame(1'b0, 11, bits, inh, ok);
      begin
        repeat (100) @(negedge CLOCK_50);
        send_data = 8'h55;
        send_req  = 1'b1;
        @(negedge CLOCK_50);
        send_req  = 1'b0;
        send_data = 8'h00;
      end
    join
    wait_not_busy(500, to);
    repeat (100) @(negedge CLOCK_50);
    total_cnt += 3;
    if (!ok || bits !== 11'b1_1_00001111_0)
      $display("FAIL ignore_frame got %b want %b", bits, 11'b1_1_00001111_0);
    else pass_cnt++;
    if (to || done_cnt != 1 || err_cnt != 0)
      $display("FAIL ignore_done got %0d/%0d want 1/0", done_cnt, err_cnt);
    else pass_cnt++;
    if (busy !== 1'b0 || ps2_clk_oe !== 1'b0)
      $display("FAIL ignore_no_queue got busy=%b clk_oe=%b want 0 0", busy, ps2_clk_oe);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    int inh;
    bit ok;
    bit to;
    send_byte(8'h00);
    device_frame(1'b0, 3, bits, inh, ok);
    dev_clk = 1'b0;
    repeat (H) @(negedge CLOCK_50);
    total_cnt += 2;
    if (!ok || ps2_dat_oe !== 1'b1)
      $display("FAIL mid_dat_oe got %b want 1", ps2_dat_oe);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge CLOCK_50);
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_reset got clk=%b dat=%b busy=%b want 0 0 0", ps2_clk_oe, ps2_dat_oe, busy);
    else pass_cnt++;
    reset   = 1'b0;
    dev_clk = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    clear_mon();
    send_byte(8'hF4);
    device_frame(1'b0, 11, bits, inh, ok);
    wait_not_busy(500, to);
    total_cnt += 2;
    if (!ok || bits !== 11'b1_0_11110100_0)
      $display("FAIL post_reset_frame got %b want %b", bits, 11'b1_0_11110100_0);
    else pass_cnt++;
    if (to || done_cnt != 1 || err_cnt != 0)
      $display("FAIL post_reset_done got %0d/%0d want 1/0", done_cnt, err_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_enable();
    test_parity_frames();
    test_nack();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
